serdes_bitslip: RTL

SERDES_BITSLIP -- requirements
Module: serdes_bitslip

---
 rtl/serdes_bitslip.sv | 121 ++++++++++++
 1 files changed

// File: rtl/serdes_bitslip.sv
// Serial lane transceiver: rx slice select, edge retiming and deserializer with bitslip,
// plus an independent tx serializer that can be looped back into the rx path.
module serdes_bitslip #(
  parameter int NDIVBY  = 8,
  parameter int LANEW   = 2,
  parameter int NSLICES = 3,
  parameter int WDIVBY  = $clog2(NDIVBY)
) (
  input  logic                       clks,
  input  logic                       reset,
  input  logic [NSLICES*LANEW-1:0]   rx_in,
  input  logic [NDIVBY*LANEW-1:0]    tx_in,
  input  logic [1:0]                 config_rx_sel,
  input  logic                       config_rx_edge_sel,
  input  logic                       config_loopback,
  input  logic                       config_bitslip,
  output logic [NDIVBY*LANEW-1:0]    rx_out,
  output logic                       rx_valid,
  output logic                       tx_load,
  output logic [LANEW-1:0]           tx_out
);

  localparam int WORDW = NDIVBY * LANEW;
  localparam logic [WDIVBY-1:0] LAST = WDIVBY'(NDIVBY - 1);

  logic [1:0]        sel_d;
  logic              edge_d;
  logic              lb_d;
  logic              slip_d;

  logic [LANEW-1:0]  slice;
  logic [LANEW-1:0]  slice_rev;
  logic [LANEW-1:0]  mux_rev;
  logic [LANEW-1:0]  neg_q;
  logic [LANEW-1:0]  neg_d;
  logic [LANEW-1:0]  pos_d;
  logic [LANEW-1:0]  rx_in_d;

  logic [WORDW-1:0]  rx_buffer;
  logic [WORDW-1:0]  tx_buffer;
  logic [WDIVBY-1:0] rx_count;
  logic [WDIVBY-1:0] tx_count;

  always_ff @(posedge clks) begin
    if (reset) begin
      sel_d  <= '0;
      edge_d <= 1'b0;
      lb_d   <= 1'b0;
      slip_d <= 1'b0;
    end else begin
      sel_d  <= config_rx_sel;
      edge_d <= config_rx_edge_sel;
      lb_d   <= config_loopback;
      slip_d <= config_bitslip;
    end
  end

  // Out-of-range selects clamp to the last slice.
  always_comb begin
    int idx;
    idx = int'(sel_d);
    if (idx >= NSLICES) idx = NSLICES - 1;
    slice = '0;
    for (int s = 0; s < NSLICES; s++) begin
      if (idx == s) slice = rx_in[s*LANEW +: LANEW];
    end
    slice_rev = '0;
    for (int i = 0; i < LANEW; i++) slice_rev[i] = slice[LANEW-1-i];
    mux_rev = lb_d ? tx_out : slice_rev;
  end

  // Unreset on purpose: it is flushed through neg_d before reaching rx_buffer.
  always_ff @(negedge clks) begin
    neg_q <= mux_rev;
  end

  always_ff @(posedge clks) begin
    if (reset) begin
      neg_d     <= '0;
      pos_d     <= '0;
      rx_in_d   <= '0;
      rx_buffer <= '0;
      rx_count  <= '0;
      rx_out    <= '0;
      rx_valid  <= 1'b0;
    end else begin
      neg_d     <= neg_q;
      pos_d     <= mux_rev;
      rx_in_d   <= edge_d ? neg_d : pos_d;
      rx_buffer <= {rx_in_d, rx_buffer[WORDW-1:LANEW]};
      rx_valid  <= 1'b0;
      // A slip holds the counter, pushing the word boundary one group later.
      if (!slip_d) begin
        if (rx_count == LAST) begin
          rx_count <= '0;
          rx_out   <= rx_buffer;
          rx_valid <= 1'b1;
        end else begin
          rx_count <= rx_count + WDIVBY'(1);
        end
      end
    end
  end

  always_ff @(posedge clks) begin
    if (reset) begin
      tx_buffer <= '0;
      tx_count  <= '0;
    end else if (tx_count == LAST) begin
      tx_buffer <= tx_in;
      tx_count  <= '0;
    end else begin
      tx_buffer <= {{LANEW{1'b0}}, tx_buffer[WORDW-1:LANEW]};
      tx_count  <= tx_count + WDIVBY'(1);
    end
  end

  assign tx_load = (tx_count == LAST) && !reset;
  assign tx_out  = tx_buffer[LANEW-1:0];

endmodule
